// File: rtl/spi_master_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : spi_master_cfg
//  Brief    : Parametrised SPI master with configurable word width, SCLK
//             divider, CPOL/CPHA mode, bit order and one-hot chip selects.
//  Revision : 1.0  initial release
// ============================================================================
module spi_master_cfg #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 2,
    parameter int NUM_CS  = 4,
    parameter int CS_IW   = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic [CS_IW-1:0]  cs_idx,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              done,
    output logic              busy,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_CS-1:0] cs_n
);

    localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int EDGE_W = $clog2(2 * DATA_W);
    localparam logic [DIV_W-1:0]  C_DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [EDGE_W-1:0] C_EDGE_LAST = EDGE_W'(2 * DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_XFER  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [EDGE_W-1:0]   edge_q, edge_d;
    logic                cpha_q, cpha_d;
    logic                lsb_q, lsb_d;
    logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
    logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                done_q, done_d;
    logic                busy_q, busy_d;
    logic                sclk_q, sclk_d;
    logic                mosi_q, mosi_d;
    logic [NUM_CS-1:0]   cs_n_q, cs_n_d;
    logic [NUM_CS-1:0]   cs_sel_n;
    logic                div_tick;

    function automatic logic head_bit(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? w[0] : w[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] w, input logic lsb);
        return lsb ? (w >> 1) : (w << 1);
    endfunction

    // Out-of-range indices match no line, so the transfer runs deselected.
    always_comb begin
        cs_sel_n = '1;
        for (int i = 0; i < NUM_CS; i++) begin
            if (cs_idx == CS_IW'(i)) cs_sel_n[i] = 1'b0;
        end
    end

    assign div_tick = (div_q == C_DIV_LAST);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        edge_d    = edge_q;
        cpha_d    = cpha_q;
        lsb_d     = lsb_q;
        tx_sh_d   = tx_sh_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        done_d    = 1'b0;
        busy_d    = busy_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;

        case (state_q)
            S_IDLE: begin
                sclk_d = cpol;
                mosi_d = 1'b0;
                cs_n_d = '1;
                if (start) begin
                    state_d = S_SETUP;
                    busy_d  = 1'b1;
                    cs_n_d  = cs_sel_n;
                    cpha_d  = cpha;
                    lsb_d   = lsb_first;
                    div_d   = '0;
                    edge_d  = '0;
                    rx_sh_d = '0;
                    // Mode cpha=0 must present the first bit before the first edge.
                    if (!cpha) begin
                        mosi_d  = head_bit(tx_data, lsb_first);
                        tx_sh_d = shift_out(tx_data, lsb_first);
                    end else begin
                        tx_sh_d = tx_data;
                    end
                end
            end
            S_SETUP: begin
                div_d = div_q + DIV_W'(1);
                if (div_tick) begin
                    div_d   = '0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                div_d = div_q + DIV_W'(1);
                if (div_tick) begin
                    div_d  = '0;
                    sclk_d = ~sclk_q;
                    // Even edge index == leading edge (edge 1, 3, ...).
                    if (!edge_q[0]) begin
                        if (cpha_q) begin
                            mosi_d  = head_bit(tx_sh_q, lsb_q);
                            tx_sh_d = shift_out(tx_sh_q, lsb_q);
                        end else begin
                            rx_sh_d = lsb_q ? {miso, rx_sh_q[DATA_W-1:1]}
                                            : {rx_sh_q[DATA_W-2:0], miso};
                        end
                    end else begin
                        if (cpha_q) begin
                            rx_sh_d = lsb_q ? {miso, rx_sh_q[DATA_W-1:1]}
                                            : {rx_sh_q[DATA_W-2:0], miso};
                        end else if (edge_q != C_EDGE_LAST) begin
                            mosi_d  = head_bit(tx_sh_q, lsb_q);
                            tx_sh_d = shift_out(tx_sh_q, lsb_q);
                        end
                    end
                    if (edge_q == C_EDGE_LAST) begin
                        state_d = S_HOLD;
                    end else begin
                        edge_d = edge_q + EDGE_W'(1);
                    end
                end
            end
            S_HOLD: begin
                div_d = div_q + DIV_W'(1);
                if (div_tick) begin
                    div_d     = '0;
                    state_d   = S_IDLE;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    cs_n_d    = '1;
                    mosi_d    = 1'b0;
                    rx_data_d = rx_sh_q;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                cs_n_d  = '1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            edge_q    <= '0;
            cpha_q    <= 1'b0;
            lsb_q     <= 1'b0;
            tx_sh_q   <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= '1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            cpha_q    <= cpha_d;
            lsb_q     <= lsb_d;
            tx_sh_q   <= tx_sh_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            done_q    <= done_d;
            busy_q    <= busy_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
        end
    end

    assign rx_data = rx_data_q;
    assign done    = done_q;
    assign busy    = busy_q;
    assign sclk    = sclk_q;
    assign mosi    = mosi_q;
    assign cs_n    = cs_n_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_master_cfg.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_master_cfg
//  Brief    : Directed self-checking bench for spi_master_cfg (H=2 and H=1).
//  Revision : 1.0  initial release
// ============================================================================
module tb_spi_master_cfg;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, cpol, cpha, lsb_first, sel, loop;
    logic [2:0] cs_idx;
    logic [7:0] tx_data;
    logic       start_a, start_b, miso_a, miso_b;
    logic [7:0] rx_a, rx_b;
    logic       done_a, done_b, busy_a, busy_b, sclk_a, sclk_b, mosi_a, mosi_b;
    logic [3:0] cs_n_a, cs_n_b;
    logic       ob_busy, ob_done, ob_sclk;
    logic [7:0] ob_rx;
    logic [3:0] ob_cs_n;

    int n_cmp = 0;
    int n_bad = 0;
    int mid_at = 0;

    // Slave model state (instance A only)
    logic       s_cpol, s_cpha, s_lsb, s_active, s_miso;
    logic [7:0] s_word, s_rx;
    int         s_cnt, s_samp, s_edges;

    always #5 clk = ~clk;

    assign start_a = start & ~sel;
    assign start_b = start & sel;
    assign miso_a  = loop ? mosi_a : s_miso;
    assign miso_b  = mosi_b;
    assign ob_busy = sel ? busy_b : busy_a;
    assign ob_done = sel ? done_b : done_a;
    assign ob_sclk = sel ? sclk_b : sclk_a;
    assign ob_rx   = sel ? rx_b   : rx_a;
    assign ob_cs_n = sel ? cs_n_b : cs_n_a;

    spi_master_cfg #(.DATA_W(8), .CLK_DIV(2), .NUM_CS(4), .CS_IW(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .cs_idx(cs_idx[1:0]), .tx_data(tx_data),
        .rx_data(rx_a), .done(done_a), .busy(busy_a), .sclk(sclk_a),
        .mosi(mosi_a), .miso(miso_a), .cs_n(cs_n_a)
    );

    spi_master_cfg #(.DATA_W(8), .CLK_DIV(1), .NUM_CS(4), .CS_IW(3)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .cpol(cpol), .cpha(cpha),
        .lsb_first(lsb_first), .cs_idx(cs_idx), .tx_data(tx_data),
        .rx_data(rx_b), .done(done_b), .busy(busy_b), .sclk(sclk_b),
        .mosi(mosi_b), .miso(miso_b), .cs_n(cs_n_b)
    );

    // Slave: drives s_word, updates on the non-sampling edge, captures mosi on the sampling edge.
    always @(posedge busy_a or negedge busy_a or posedge sclk_a or negedge sclk_a) begin
        if (!busy_a) begin
            s_active = 1'b0;
        end else if (!s_active) begin
            s_active = 1'b1;
            s_rx = 8'h00; s_samp = 0; s_edges = 0; s_cnt = 0; s_miso = 1'b0;
            if (!s_cpha) begin
                s_miso = s_word[s_lsb ? 0 : 7];
                s_cnt  = 1;
            end
        end else begin
            s_edges = s_edges + 1;
            if ((sclk_a != s_cpol) == !s_cpha) begin
                if (s_samp < 8) begin
                    s_rx[s_lsb ? s_samp : 7 - s_samp] = mosi_a;
                    s_samp = s_samp + 1;
                end
            end else if (s_cnt < 8) begin
                s_miso = s_word[s_lsb ? s_cnt : 7 - s_cnt];
                s_cnt  = s_cnt + 1;
            end
        end
    end

    task automatic wait_done(output int nb);
        nb = 0;
        while (ob_busy && nb < 200) begin
            nb++;
            if (nb == mid_at) begin
                start   = 1'b1;
                tx_data = 8'h00;
            end
            @(negedge clk);
            start = 1'b0;
        end
    endtask

    task automatic run_xfer(input logic pol, input logic pha, input logic lsb,
                            input logic [2:0] idx, input logic [7:0] tx,
                            output logic busy1, output logic [3:0] cs1, output int nb);
        @(negedge clk);
        cpol = pol; cpha = pha; lsb_first = lsb; cs_idx = idx; tx_data = tx;
        s_cpol = pol; s_cpha = pha; s_lsb = lsb;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy1 = ob_busy;
        cs1   = ob_cs_n;
        wait_done(nb);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (rx_a !== 8'h00) begin n_bad++; $display("FAIL reset_rx: got %h expected 00", rx_a); end
        n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy_a); end
        n_cmp++; if (sclk_a !== 1'b0) begin n_bad++; $display("FAIL reset_sclk: got %b expected 0", sclk_a); end
        n_cmp++; if (mosi_a !== 1'b0) begin n_bad++; $display("FAIL reset_mosi: got %b expected 0", mosi_a); end
        n_cmp++; if (cs_n_a !== 4'hF) begin n_bad++; $display("FAIL reset_cs_n: got %b expected 1111", cs_n_a); end
        n_cmp++; if (cs_n_b !== 4'hF) begin n_bad++; $display("FAIL reset_cs_n_b: got %b expected 1111", cs_n_b); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_mode0_loopback;
        logic b1; logic [3:0] c1; int nb;
        sel = 1'b0; loop = 1'b1;
        run_xfer(1'b0, 1'b0, 1'b0, 3'd0, 8'hA5, b1, c1, nb);
        n_cmp++; if (b1 !== 1'b1) begin n_bad++; $display("FAIL m0_busy_k1: got %b expected 1", b1); end
        n_cmp++; if (c1 !== 4'b1110) begin n_bad++; $display("FAIL m0_cs_n: got %b expected 1110", c1); end
        n_cmp++; if (nb !== 36) begin n_bad++; $display("FAIL m0_busy_len: got %0d expected 36", nb); end
        n_cmp++; if (ob_done !== 1'b1) begin n_bad++; $display("FAIL m0_done: got %b expected 1", ob_done); end
        n_cmp++; if (ob_rx !== 8'hA5) begin n_bad++; $display("FAIL m0_rx: got %h expected a5", ob_rx); end
        n_cmp++; if (ob_cs_n !== 4'hF) begin n_bad++; $display("FAIL m0_cs_done: got %b expected 1111", ob_cs_n); end
        @(negedge clk);
        n_cmp++; if (ob_done !== 1'b0) begin n_bad++; $display("FAIL m0_done_pulse: got %b expected 0", ob_done); end
        n_cmp++; if (ob_rx !== 8'hA5) begin n_bad++; $display("FAIL m0_rx_hold: got %h expected a5", ob_rx); end
    endtask

    task automatic test_mode3_lsb;
        logic b1; logic [3:0] c1; int nb;
        sel = 1'b0; loop = 1'b0; s_word = 8'h81;
        run_xfer(1'b1, 1'b1, 1'b1, 3'd1, 8'h3C, b1, c1, nb);
        n_cmp++; if (c1 !== 4'b1101) begin n_bad++; $display("FAIL m3_cs_n: got %b expected 1101", c1); end
        n_cmp++; if (nb !== 36) begin n_bad++; $display("FAIL m3_busy_len: got %0d expected 36", nb); end
        n_cmp++; if (ob_rx !== 8'h81) begin n_bad++; $display("FAIL m3_rx: got %h expected 81", ob_rx); end
        n_cmp++; if (s_edges !== 16) begin n_bad++; $display("FAIL m3_edges: got %0d expected 16", s_edges); end
        n_cmp++; if (s_samp !== 8) begin n_bad++; $display("FAIL m3_samples: got %0d expected 8", s_samp); end
        n_cmp++; if (s_rx !== 8'h3C) begin n_bad++; $display("FAIL m3_mosi_order: got %h expected 3c", s_rx); end
        repeat (2) @(negedge clk);
        n_cmp++; if (ob_sclk !== 1'b1) begin n_bad++; $display("FAIL m3_sclk_idle: got %b expected 1", ob_sclk); end
    endtask

    task automatic test_modes_1_2;
        logic b1; logic [3:0] c1; int nb;
        sel = 1'b0; loop = 1'b0;
        s_word = 8'hC3;
        run_xfer(1'b0, 1'b1, 1'b0, 3'd2, 8'h5A, b1, c1, nb);
        n_cmp++; if (ob_rx !== 8'hC3) begin n_bad++; $display("FAIL m1_rx: got %h expected c3", ob_rx); end
        n_cmp++; if (s_rx !== 8'h5A) begin n_bad++; $display("FAIL m1_slave_rx: got %h expected 5a", s_rx); end
        s_word = 8'h96;
        run_xfer(1'b1, 1'b0, 1'b0, 3'd3, 8'h5A, b1, c1, nb);
        n_cmp++; if (ob_rx !== 8'h96) begin n_bad++; $display("FAIL m2_rx: got %h expected 96", ob_rx); end
        n_cmp++; if (s_rx !== 8'h5A) begin n_bad++; $display("FAIL m2_slave_rx: got %h expected 5a", s_rx); end
        n_cmp++; if (s_edges !== 16) begin n_bad++; $display("FAIL m2_edges: got %0d expected 16", s_edges); end
    endtask

    task automatic test_back_to_back;
        logic b1; logic [3:0] c1; int nb;
        sel = 1'b0; loop = 1'b1; mid_at = 10;
        run_xfer(1'b0, 1'b0, 1'b0, 3'd0, 8'h96, b1, c1, nb);
        mid_at = 0;
        n_cmp++; if (nb !== 36) begin n_bad++; $display("FAIL b2b_first_len: got %0d expected 36", nb); end
        n_cmp++; if (ob_rx !== 8'h96) begin n_bad++; $display("FAIL b2b_first_rx: got %h expected 96", ob_rx); end
        n_cmp++; if (ob_done !== 1'b1) begin n_bad++; $display("FAIL b2b_first_done: got %b expected 1", ob_done); end
        tx_data = 8'h3C; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_cmp++; if (ob_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_gap: got busy %b expected 1", ob_busy); end
        wait_done(nb);
        n_cmp++; if (nb !== 36) begin n_bad++; $display("FAIL b2b_second_len: got %0d expected 36", nb); end
        n_cmp++; if (ob_rx !== 8'h3C) begin n_bad++; $display("FAIL b2b_second_rx: got %h expected 3c", ob_rx); end
    endtask

    task automatic test_reset_mid;
        logic b1; logic [3:0] c1; int nb; int pulses;
        sel = 1'b0; loop = 1'b1;
        @(negedge clk);
        cpol = 1'b1; cpha = 1'b1; lsb_first = 1'b0; cs_idx = 3'd2; tx_data = 8'h77;
        s_cpol = 1'b1; s_cpha = 1'b1; s_lsb = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (17) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++; if (cs_n_a !== 4'hF) begin n_bad++; $display("FAIL rst_mid_cs_n: got %b expected 1111", cs_n_a); end
        n_cmp++; if (sclk_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_sclk: got %b expected 0", sclk_a); end
        n_cmp++; if (busy_a !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy_a); end
        pulses = 0;
        repeat (2) begin @(negedge clk); if (done_a) pulses++; end
        rst_n = 1'b1;
        repeat (40) begin @(negedge clk); if (done_a) pulses++; end
        n_cmp++; if (pulses !== 0) begin n_bad++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", pulses); end
        run_xfer(1'b0, 1'b0, 1'b0, 3'd0, 8'hFF, b1, c1, nb);
        n_cmp++; if (ob_rx !== 8'hFF) begin n_bad++; $display("FAIL rst_mid_next_rx: got %h expected ff", ob_rx); end
    endtask

    task automatic test_fast_div;
        logic b1; logic [3:0] c1; int nb;
        sel = 1'b1;
        run_xfer(1'b0, 1'b0, 1'b0, 3'd3, 8'h6B, b1, c1, nb);
        n_cmp++; if (c1 !== 4'b0111) begin n_bad++; $display("FAIL h1_cs_n: got %b expected 0111", c1); end
        n_cmp++; if (nb !== 18) begin n_bad++; $display("FAIL h1_busy_len: got %0d expected 18", nb); end
        n_cmp++; if (ob_rx !== 8'h6B) begin n_bad++; $display("FAIL h1_rx: got %h expected 6b", ob_rx); end
        run_xfer(1'b0, 1'b0, 1'b1, 3'd4, 8'hD2, b1, c1, nb);
        n_cmp++; if (c1 !== 4'b1111) begin n_bad++; $display("FAIL h1_oor_cs_n: got %b expected 1111", c1); end
        n_cmp++; if (nb !== 18) begin n_bad++; $display("FAIL h1_oor_busy_len: got %0d expected 18", nb); end
        n_cmp++; if (ob_done !== 1'b1) begin n_bad++; $display("FAIL h1_oor_done: got %b expected 1", ob_done); end
        n_cmp++; if (ob_rx !== 8'hD2) begin n_bad++; $display("FAIL h1_oor_rx: got %h expected d2", ob_rx); end
        sel = 1'b0;
    endtask

    initial begin
        start = 1'b0; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0; sel = 1'b0; loop = 1'b1;
        cs_idx = 3'd0; tx_data = 8'h00;
        s_cpol = 1'b0; s_cpha = 1'b0; s_lsb = 1'b0; s_active = 1'b0; s_miso = 1'b0;
        s_word = 8'h00; s_rx = 8'h00; s_cnt = 0; s_samp = 0; s_edges = 0;
        test_reset;
        test_mode0_loopback;
        test_mode3_lsb;
        test_modes_1_2;
        test_back_to_back;
        test_reset_mid;
        test_fast_div;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
